// File: rtl/huffman_pkg.sv
`default_nettype none
// ============================================================================
// huffman_pkg : constants, packer state type and popcount helper
// Revision    : 1.0
// ============================================================================
package huffman_pkg;

    localparam int NSYM   = 6;
    localparam int CODE_W = 8;
    localparam int OUT_W  = 8;
    localparam int ACC_W  = 2 * OUT_W;
    localparam int LEN_W  = 4;
    localparam int FILL_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } pack_state_t;

    function automatic logic [LEN_W-1:0] popcount8(input logic [CODE_W-1:0] v);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int i = 0; i < CODE_W; i++) begin
            n = n + {{(LEN_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/huffman_code_table.sv
`default_nettype none
// ============================================================================
// huffman_code_table : latched code/length table with combinational lookup
// Revision           : 1.0
// ============================================================================
module huffman_code_table
    import huffman_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         load,
    input  logic [NSYM-1:0][CODE_W-1:0]  hc_in,
    input  logic [NSYM-1:0][CODE_W-1:0]  mask_in,
    input  logic [7:0]                   sym,
    output logic [CODE_W-1:0]            code,
    output logic [LEN_W-1:0]             len,
    output logic                         illegal
);

    logic [CODE_W-1:0] r_hc  [NSYM];
    logic [LEN_W-1:0]  r_len [NSYM];

    // Codes are stored pre-masked to their length so lookup needs no masking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSYM; i++) begin
                r_hc[i]  <= '0;
                r_len[i] <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NSYM; i++) begin
                r_len[i] <= popcount8(mask_in[i]);
                r_hc[i]  <= hc_in[i] & ~({CODE_W{1'b1}} << popcount8(mask_in[i]));
            end
        end
    end

    always_comb begin
        code    = '0;
        len     = '0;
        illegal = 1'b1;
        for (int i = 0; i < NSYM; i++) begin
            if (sym == 8'(i + 1)) begin
                code    = r_hc[i];
                len     = r_len[i];
                illegal = (r_len[i] == '0);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/huffman_packer.sv
`default_nettype none
// ============================================================================
// huffman_packer : packs variable-length codes MSB-first into output bytes
// Revision       : 1.0
// ============================================================================
module huffman_packer
    import huffman_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              sym_valid,
    input  logic [7:0]        sym_data,
    input  logic              sym_last,
    output logic              sym_ready,
    output logic              out_valid,
    output logic [OUT_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              done,
    output logic              err
);

    pack_state_t        r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [FILL_W-1:0]  r_fill;
    logic               r_err;

    logic [CODE_W-1:0]  w_code;
    logic [LEN_W-1:0]   w_len;
    logic               w_illegal;
    logic               w_load;
    logic               w_sym_acc;
    logic               w_out_hs;
    logic [ACC_W-1:0]   w_acc_shift;
    logic [FILL_W-1:0]  w_fill_shift;
    logic [CODE_W-1:0]  w_code_lj;
    logic [ACC_W-1:0]   w_ins;
    logic [ACC_W-1:0]   w_acc_next;
    logic [FILL_W-1:0]  w_fill_next;

    assign w_load = (r_state == ST_IDLE) && code_valid;

    huffman_code_table u_table (
        .clk     (clk),
        .reset   (reset),
        .load    (w_load),
        .hc_in   ({HC6, HC5, HC4, HC3, HC2, HC1}),
        .mask_in ({M6, M5, M4, M3, M2, M1}),
        .sym     (sym_data),
        .code    (w_code),
        .len     (w_len),
        .illegal (w_illegal)
    );

    assign sym_ready = (r_state == ST_RUN) && (r_fill <= 5'd8);
    assign out_valid = (r_fill >= 5'd8) || ((r_state == ST_FLUSH) && (r_fill != '0));
    assign out_data  = r_acc[ACC_W-1 -: OUT_W];
    assign done      = (r_state == ST_DONE);
    assign err       = r_err;

    assign w_sym_acc = sym_valid && sym_ready;
    assign w_out_hs  = out_valid && out_ready;

    // A byte leaving and a code arriving in the same cycle: shift first, then
    // insert the new code directly behind the post-shift fill point.
    always_comb begin
        w_acc_shift  = w_out_hs ? (r_acc << OUT_W) : r_acc;
        w_fill_shift = r_fill;
        if (w_out_hs) begin
            w_fill_shift = (r_fill >= 5'd8) ? (r_fill - 5'd8) : '0;
        end
        w_code_lj   = w_code << (LEN_W'(CODE_W) - w_len);
        w_ins       = {w_code_lj, {(ACC_W-CODE_W){1'b0}}} >> w_fill_shift;
        w_acc_next  = w_acc_shift;
        w_fill_next = w_fill_shift;
        if (w_sym_acc && !w_illegal) begin
            w_acc_next  = w_acc_shift | w_ins;
            w_fill_next = w_fill_shift + {1'b0, w_len};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_fill  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_acc  <= w_acc_next;
            r_fill <= w_fill_next;
            case (r_state)
                ST_IDLE: begin
                    if (code_valid) begin
                        r_state <= ST_RUN;
                        r_acc   <= '0;
                        r_fill  <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_sym_acc && w_illegal) begin
                        r_err <= 1'b1;
                    end
                    if (w_sym_acc && sym_last) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (r_fill == '0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_huffman_packer.sv
`default_nettype none
// ============================================================================
// tb_huffman_packer : directed and randomized checks against a bit-queue model
// Revision          : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_huffman_packer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       code_valid;
    logic [7:0] hc_t [1:6];
    logic [7:0] m_t  [1:6];
    logic       sym_valid;
    logic [7:0] sym_data;
    logic       sym_last;
    logic       sym_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic       done;
    logic       err;

    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         ready_mode = 1;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    bit         exp_err;
    int         stim[$];
    int         last_hs_cyc;
    int         done_cyc;
    bit         done_seen;
    int         done_count;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;

    huffman_packer dut (
        .clk        (clk),
        .reset      (rst_n),
        .code_valid (code_valid),
        .HC1        (hc_t[1]),
        .HC2        (hc_t[2]),
        .HC3        (hc_t[3]),
        .HC4        (hc_t[4]),
        .HC5        (hc_t[5]),
        .HC6        (hc_t[6]),
        .M1         (m_t[1]),
        .M2         (m_t[2]),
        .M3         (m_t[3]),
        .M4         (m_t[4]),
        .M5         (m_t[5]),
        .M6         (m_t[6]),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_last   (sym_last),
        .sym_ready  (sym_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Output monitor: collects bytes, handshake/done timing, and hold-while-stalled.
    always @(negedge clk) begin
        if (prev_stall && rst_n === 1'b1) begin
            tests++;
            assert (out_valid === 1'b1 && out_data === prev_data) else begin
                fails++;
                $error("FAIL hold: observed valid=%b data=%h expected valid=1 data=%h",
                       out_valid, out_data, prev_data);
            end
        end
        prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0) && (rst_n === 1'b1);
        prev_data  = out_data;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            got.push_back(out_data);
            last_hs_cyc = cyc;
        end
        if (done === 1'b1) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            done_count++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: concatenate code bits MSB-first, zero-pad, cut into bytes.
    task automatic model();
        bit bits[$];
        int s;
        int l;
        logic [7:0] v;
        exp_q.delete();
        exp_err = 1'b0;
        foreach (stim[i]) begin
            s = stim[i];
            if (s < 1 || s > 6) begin
                exp_err = 1'b1;
            end else begin
                l = $countones(m_t[s]);
                if (l == 0) exp_err = 1'b1;
                for (int b = l - 1; b >= 0; b--) bits.push_back(hc_t[s][b]);
            end
        end
        while (bits.size() % 8 != 0) bits.push_back(1'b0);
        for (int k = 0; k < bits.size(); k += 8) begin
            for (int j = 0; j < 8; j++) v[7-j] = bits[k+j];
            exp_q.push_back(v);
        end
    endtask

    task automatic set_std_table();
        hc_t[1] = 8'h01; m_t[1] = 8'h01;
        hc_t[2] = 8'h00; m_t[2] = 8'h03;
        hc_t[3] = 8'h03; m_t[3] = 8'h07;
        hc_t[4] = 8'h05; m_t[4] = 8'h0F;
        hc_t[5] = 8'h08; m_t[5] = 8'h1F;
        hc_t[6] = 8'h09; m_t[6] = 8'h1F;
    endtask

    task automatic load_table();
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        check("load_sym_ready", sym_ready, 1);
    endtask

    task automatic send_sym(input int s, input bit last, input bit gaps);
        int budget;
        budget = 0;
        if (gaps && $urandom_range(0, 3) == 0) tick();
        sym_valid = 1'b1;
        sym_data  = 8'(s);
        sym_last  = last;
        forever begin
            @(negedge clk);
            if (sym_ready === 1'b1) begin
                tick();
                break;
            end
            tick();
            budget++;
            if (budget > 300) begin
                tests++;
                fails++;
                $error("FAIL accept_timeout: observed sym_ready=%b expected 1", sym_ready);
                break;
            end
        end
        sym_valid = 1'b0;
        sym_last  = 1'b0;
    endtask

    task automatic start_stream(input bit gaps);
        model();
        got.delete();
        done_seen  = 1'b0;
        done_count = 0;
        foreach (stim[i]) send_sym(stim[i], i == stim.size() - 1, gaps);
    endtask

    task automatic finish_stream(input string tag);
        int budget;
        budget = 0;
        while (!done_seen && budget < 500) begin
            tick();
            budget++;
        end
        check({tag, "_done_seen"}, done_seen, 1);
        tick();
        tick();
        check({tag, "_done_count"}, done_count, 1);
        check({tag, "_done_latency"}, done_cyc - last_hs_cyc, 2);
        check({tag, "_nbytes"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
        end
        check({tag, "_err"}, err, exp_err);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int s;
        rst_n      = 1'b0;
        code_valid = 1'b0;
        sym_valid  = 1'b0;
        sym_data   = 8'h00;
        sym_last   = 1'b0;
        set_std_table();
        repeat (2) tick();

        check("rst_sym_ready", sym_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_done",      done,      0);
        check("rst_err",       err,       0);
        rst_n = 1'b1;
        tick();
        check("idle_sym_ready", sym_ready, 0);

        ready_mode = 1;
        load_table(); stim = {1, 1, 1, 1, 1, 1, 1, 1}; start_stream(0); finish_stream("ones");
        load_table(); stim = {2, 2, 2, 2};             start_stream(0); finish_stream("zeros");
        load_table(); stim = {3, 4};                   start_stream(0); finish_stream("pad");
        load_table(); stim = {5, 6};                   start_stream(0); finish_stream("two");

        // Backpressure: fill reaches 9 with the output stalled.
        ready_mode = 0;
        tick(); tick();
        load_table();
        stim = {1, 1, 1, 1, 1, 1, 1, 1, 1};
        start_stream(0);
        for (int i = 0; i < 3; i++) begin
            check("bp_sym_ready", sym_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data",  out_data,  8'hFF);
            tick();
        end
        ready_mode = 1;
        finish_stream("bp");

        // Illegal symbol mid-stream, then reset during RUN.
        load_table();
        got.delete();
        stim = {1, 1, 7, 1, 1, 1, 1, 1, 1};
        foreach (stim[i]) send_sym(stim[i], 1'b0, 1'b0);
        tick(); tick();
        check("ill_err",    err,        1);
        check("ill_nbytes", got.size(), 1);
        if (got.size() > 0) check("ill_byte0", got[0], 8'hFF);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sym_ready", sym_ready, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data",  out_data,  0);
        check("mid_rst_done",      done,      0);
        check("mid_rst_err",       err,       0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_sym_ready", sym_ready, 0);
        check("post_rst_out_valid", out_valid, 0);

        // Randomized tables, streams and output backpressure.
        ready_mode = 2;
        for (int t = 0; t < 25; t++) begin
            for (int k = 1; k <= 6; k++) begin
                n = $urandom_range(0, 8);
                if (k == 1 && n == 0) n = 1;
                hc_t[k] = 8'($urandom);
                m_t[k]  = 8'((1 << n) - 1);
            end
            load_table();
            stim.delete();
            n = $urandom_range(0, 19);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) == 0) stim.push_back($urandom_range(0, 255));
                else                           stim.push_back($urandom_range(1, 6));
            end
            do s = $urandom_range(1, 6); while ($countones(m_t[s]) == 0);
            stim.push_back(s);
            start_stream(1);
            finish_stream($sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
